// File: rtl/nes_cap_pkg.sv
// nes_cap_pkg: shared geometry constants, capture FSM states and the FIFO word layout
// for the NES frame streamer.
package nes_cap_pkg;

  localparam int unsigned H_VIS          = 256;
  localparam int unsigned V_VIS          = 240;
  localparam int unsigned WORDS_PER_LINE = 64;
  localparam int unsigned DATA_W         = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_RESYNC
  } cap_state_t;

  typedef struct packed {
    logic              tuser;
    logic              tlast;
    logic [DATA_W-1:0] tdata;
  } cap_word_t;

  localparam int unsigned WORD_W = $bits(cap_word_t);

endpackage

// File: rtl/nes_cap_fifo.sv
// nes_cap_fifo: synchronous first-word-fall-through FIFO. The head entry is presented
// straight from the storage flops, so a word written into an empty FIFO is visible the
// next cycle. A write into a full FIFO is accepted when a read happens on the same edge.
module nes_cap_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_wr;
  logic             w_rd;

  assign w_rd        = i_rd_en && !r_empty;
  assign w_wr        = i_wr_en && (!r_full || w_rd);
  assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_rd);

  // Storage, pointers and registered occupancy flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule

// File: rtl/nes_frame_streamer.sv
// nes_frame_streamer: captures the visible 256x240 NES PPU picture, packs four 6-bit
// pixels per 32-bit word and streams the words out over AXI-Stream (tuser = frame start,
// tlast = line end). Define NES_FRAME_STREAMER_STATS_EN to get live frame/drop counters;
// otherwise frame_cnt and drop_cnt read as zero.
module nes_frame_streamer
  import nes_cap_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic [5:0]  color,
  input  logic [8:0]  scanline,
  input  logic [8:0]  cycle,
  input  logic        enable,
  input  logic        single,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  cap_state_t  r_state;
  cap_state_t  w_state_nxt;
  logic [7:0]  w_x;
  logic        w_visible;
  logic        w_frame_start;
  logic        w_vblank;
  logic        w_cap_pix;
  logic [23:0] r_pack;
  cap_word_t   r_word;
  logic        r_word_vld;
  logic        r_word_eof;
  logic        r_oneshot_hold;
  logic        r_overflow;
  logic        r_busy;
  logic        w_push;
  logic        w_pop;
  logic        w_drop;
  logic        w_frame_end;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  cap_word_t   w_fifo_word;

  // Pixel classification, only meaningful on pix_ce cycles.
  assign w_x           = cycle[7:0] - 8'd1;
  assign w_visible     = pix_ce && (scanline < 9'(V_VIS)) && (cycle != 9'd0) && (cycle <= 9'(H_VIS));
  assign w_frame_start = w_visible && (scanline == 9'd0) && (cycle == 9'd1);
  assign w_vblank      = pix_ce && (scanline >= 9'(V_VIS));
  assign w_cap_pix     = w_visible &&
                         ((r_state == ST_CAPTURE) ||
                          ((r_state == ST_ARMED) && enable && w_frame_start));

  assign w_push      = r_word_vld && (r_state == ST_CAPTURE);
  assign w_pop       = m_axis_tvalid && m_axis_tready;
  assign w_drop      = w_push && w_fifo_full && !w_pop;
  assign w_frame_end = w_push && r_word_eof && !w_drop;

  // Capture FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture FSM next-state logic; capture disable only takes effect at frame end.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable && !r_oneshot_hold) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (!enable)            w_state_nxt = ST_IDLE;
        else if (w_frame_start) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (w_drop)           w_state_nxt = ST_RESYNC;
        else if (w_frame_end) w_state_nxt = (enable && !single) ? ST_ARMED : ST_IDLE;
      end
      ST_RESYNC: begin
        if (w_vblank) w_state_nxt = enable ? ST_ARMED : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pixel packer: lanes 0..2 collect in r_pack, lane 3 completes a word pushed next clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pack     <= '0;
      r_word     <= '0;
      r_word_vld <= 1'b0;
      r_word_eof <= 1'b0;
    end else begin
      r_word_vld <= 1'b0;
      if (w_cap_pix) begin
        case (w_x[1:0])
          2'd0:    r_pack[7:0]   <= {2'b00, color};
          2'd1:    r_pack[15:8]  <= {2'b00, color};
          2'd2:    r_pack[23:16] <= {2'b00, color};
          default: begin
            r_word.tdata <= {2'b00, color, r_pack};
            r_word.tlast <= (w_x[7:2] == 6'(WORDS_PER_LINE - 1));
            r_word.tuser <= (scanline == 9'd0) && (w_x[7:2] == 6'd0);
            r_word_eof   <= (scanline == 9'(V_VIS - 1)) && (w_x == 8'(H_VIS - 1));
            r_word_vld   <= 1'b1;
          end
        endcase
      end
    end
  end

  // Status: sticky overflow, busy, and one-shot hold that blocks re-arming until
  // enable is released after a single-mode frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow     <= 1'b0;
      r_busy         <= 1'b0;
      r_oneshot_hold <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_ARMED)) begin
        r_overflow <= 1'b0;
      end
      r_busy <= (w_state_nxt != ST_IDLE);
      if (!enable) begin
        r_oneshot_hold <= 1'b0;
      end else if (w_frame_end && single) begin
        r_oneshot_hold <= 1'b1;
      end
    end
  end

  nes_cap_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_wr_en   (w_push),
    .i_wr_data (r_word),
    .i_rd_en   (m_axis_tready),
    .o_rd_data (w_fifo_word),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  assign m_axis_tdata  = w_fifo_word.tdata;
  assign m_axis_tlast  = w_fifo_word.tlast;
  assign m_axis_tuser  = w_fifo_word.tuser;
  assign m_axis_tvalid = !w_fifo_empty;
  assign busy          = r_busy;
  assign overflow      = r_overflow;

`ifdef NES_FRAME_STREAMER_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_drop_cnt;

  // Completed and aborted frame counters, wrapping modulo 2^16.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_drop)      r_drop_cnt  <= r_drop_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_nes_frame_streamer.sv
// tb_nes_frame_streamer: directed bench for nes_frame_streamer. Frames are shortened to
// visible lines {0..5,10,100,239} plus a short vblank line so runs stay small.
module tb_nes_frame_streamer;

  localparam int unsigned DEPTH = 16;
`ifdef NES_FRAME_STREAMER_STATS_EN
  localparam logic [31:0] STAT_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] STAT_MASK = 32'h0;
`endif

  typedef struct packed {
    logic        u;
    logic        l;
    logic [31:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_ce;
  logic [5:0]  color;
  logic [8:0]  scanline;
  logic [8:0]  cycle;
  logic        enable;
  logic        single;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        busy;
  logic        overflow;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  nes_frame_streamer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .pix_ce        (pix_ce),
    .color         (color),
    .scanline      (scanline),
    .cycle         (cycle),
    .enable        (enable),
    .single        (single),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .busy          (busy),
    .overflow      (overflow),
    .frame_cnt     (frame_cnt),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    rdy_mode = 0;
  int    ev_kind = 0;
  int    ev_line = -1;
  int    ev_cyc = -1;
  bit    exp_on = 1'b0;
  beat_t exp_q[$];
  beat_t rx_q[$];
  int    lines[9] = '{0, 1, 2, 3, 4, 5, 10, 100, 239};

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] st(input int n);
    return 32'(n) & STAT_MASK;
  endfunction

  function automatic logic [5:0] pix_color(input int line, input int x, input int seed);
    if (seed == 0) return 6'(x);
    return 6'(x * seed + line * 3);
  endfunction

  function automatic beat_t exp_beat(input int line, input int wi, input int seed);
    beat_t b;
    b.d = '0;
    for (int n = 0; n < 4; n++) b.d[8*n +: 8] = {2'b00, pix_color(line, 4 * wi + n, seed)};
    b.l = (wi == 63);
    b.u = (line == 0) && (wi == 0);
    return b;
  endfunction

  // tready pattern: 0 = always ready, 1 = toggle every clk, 2 = stalled.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard on handshakes, hold check while stalled.
  initial begin
    bit    prev_stall;
    beat_t prev_b;
    beat_t cur;
    beat_t e;
    prev_stall = 1'b0;
    prev_b     = '0;
    forever begin
      @(negedge clk);
      cur.u = m_axis_tuser;
      cur.l = m_axis_tlast;
      cur.d = m_axis_tdata;
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk_eq("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
          chk_eq("stall_tdata", m_axis_tdata, prev_b.d);
          chk_eq("stall_flags", 32'({m_axis_tlast, m_axis_tuser}), 32'({prev_b.l, prev_b.u}));
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_b     = cur;
        if (m_axis_tvalid && m_axis_tready) begin
          rx_q.push_back(cur);
          chk_eq("word_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk_eq("tdata", m_axis_tdata, e.d);
            chk_eq("tlast_tuser", 32'({m_axis_tlast, m_axis_tuser}), 32'({e.l, e.u}));
          end
        end
      end
    end
  end

  task automatic ppu_cycle(input int line, input int cyc, input int seed);
    @(posedge clk);
    #1;
    pix_ce   = 1'b1;
    scanline = 9'(line);
    cycle    = 9'(cyc);
    color    = pix_color(line, cyc - 1, seed);
    @(posedge clk);
    #1;
    // Off-strobe garbage that would look like a frame start if sampled.
    pix_ce   = 1'b0;
    scanline = 9'd0;
    cycle    = 9'd1;
    color    = 6'($urandom);
  endtask

  task automatic do_event();
    if (ev_kind == 1) begin
      enable = 1'b0;
    end else begin
      rst = 1'b0;
      #1;
      chk_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk_eq("rst_tdata", m_axis_tdata, 32'd0);
      chk_eq("rst_flags", 32'({m_axis_tlast, m_axis_tuser}), 32'd0);
      chk_eq("rst_busy", 32'(busy), 32'd0);
      chk_eq("rst_overflow", 32'(overflow), 32'd0);
      chk_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk_eq("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      exp_q.delete();
      exp_on = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
    end
    ev_kind = 0;
  endtask

  task automatic drive_line(input int line, input int seed, input int n_exp, input int n_cyc);
    if (exp_on) for (int w = 0; w < n_exp; w++) exp_q.push_back(exp_beat(line, w, seed));
    for (int c = 0; c < n_cyc; c++) begin
      if (ev_kind != 0 && line == ev_line && c == ev_cyc) do_event();
      ppu_cycle(line, c, seed);
    end
  endtask

  task automatic run_frame(input int seed, input bit cap, input int stall_line);
    exp_on = cap;
    foreach (lines[i]) begin
      if (lines[i] == stall_line) begin
        rdy_mode = 2;
        drive_line(lines[i], seed, DEPTH, 258);
        rdy_mode = 0;
        exp_on   = 1'b0;
      end else begin
        drive_line(lines[i], seed, 64, 258);
      end
    end
    drive_line(240, seed, 0, 8);
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    rst      = 1'b1;
    pix_ce   = 1'b0;
    color    = 6'd0;
    scanline = 9'd0;
    cycle    = 9'd0;
    enable   = 1'b0;
    single   = 1'b0;
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk_eq("reset_tdata", m_axis_tdata, 32'd0);
    chk_eq("reset_flags", 32'({m_axis_tlast, m_axis_tuser}), 32'd0);
    chk_eq("reset_busy", 32'(busy), 32'd0);
    chk_eq("reset_overflow", 32'(overflow), 32'd0);
    chk_eq("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    chk_eq("reset_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("idle_busy", 32'(busy), 32'd0);

    // Basic frame, color = x[5:0].
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("armed_busy", 32'(busy), 32'd1);
    base = rx_q.size();
    run_frame(0, 1'b1, -1);
    chk_eq("f1_words", 32'(rx_q.size() - base), 32'd576);
    chk_eq("f1_word0", rx_q[base].d, 32'h0302_0100);
    chk_eq("f1_tuser0", 32'(rx_q[base].u), 32'd1);
    chk_eq("f1_word63", rx_q[base+63].d, 32'h3F3E_3D3C);
    chk_eq("f1_tlast63", 32'(rx_q[base+63].l), 32'd1);
    chk_eq("f1_pending", 32'(exp_q.size()), 32'd0);
    chk_eq("f1_frame_cnt", 32'(frame_cnt), st(1));
    chk_eq("f1_overflow", 32'(overflow), 32'd0);
    chk_eq("f1_busy", 32'(busy), 32'd1);

    // 50% backpressure.
    rdy_mode = 1;
    base = rx_q.size();
    run_frame(5, 1'b1, -1);
    rdy_mode = 0;
    chk_eq("f2_words", 32'(rx_q.size() - base), 32'd576);
    chk_eq("f2_overflow", 32'(overflow), 32'd0);
    chk_eq("f2_frame_cnt", 32'(frame_cnt), st(2));

    // Line 5 fully stalled: 16 words fit, the 17th drops, rest of frame ignored.
    base = rx_q.size();
    run_frame(7, 1'b1, 5);
    chk_eq("f3_words", 32'(rx_q.size() - base), 32'd336);
    chk_eq("f3_overflow", 32'(overflow), 32'd1);
    chk_eq("f3_drop_cnt", 32'(drop_cnt), st(1));
    chk_eq("f3_frame_cnt", 32'(frame_cnt), st(2));
    chk_eq("f3_busy", 32'(busy), 32'd1);
    base = rx_q.size();
    run_frame(9, 1'b1, -1);
    chk_eq("f4_words", 32'(rx_q.size() - base), 32'd576);
    chk_eq("f4_tuser0", 32'(rx_q[base].u), 32'd1);
    chk_eq("f4_overflow", 32'(overflow), 32'd1);
    chk_eq("f4_frame_cnt", 32'(frame_cnt), st(3));

    // One-shot: only the first of two frames is captured.
    single = 1'b1;
    base = rx_q.size();
    run_frame(11, 1'b1, -1);
    chk_eq("single_busy_a", 32'(busy), 32'd0);
    run_frame(13, 1'b0, -1);
    chk_eq("single_words", 32'(rx_q.size() - base), 32'd576);
    chk_eq("single_busy_b", 32'(busy), 32'd0);
    chk_eq("single_frame_cnt", 32'(frame_cnt), st(4));
    chk_eq("single_overflow", 32'(overflow), 32'd1);
    enable = 1'b0;
    single = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rearm_overflow", 32'(overflow), 32'd0);
    chk_eq("rearm_busy", 32'(busy), 32'd1);

    // enable dropped mid-frame at (100,50): frame still completes.
    ev_kind = 1;
    ev_line = 100;
    ev_cyc  = 50;
    base = rx_q.size();
    run_frame(15, 1'b1, -1);
    chk_eq("endrop_words", 32'(rx_q.size() - base), 32'd576);
    chk_eq("endrop_busy", 32'(busy), 32'd0);
    chk_eq("endrop_frame_cnt", 32'(frame_cnt), st(5));

    // Reset at (10,10), then resume only at the next frame start.
    enable  = 1'b1;
    ev_kind = 2;
    ev_line = 10;
    ev_cyc  = 10;
    base = rx_q.size();
    run_frame(17, 1'b1, -1);
    chk_eq("rst_words", 32'(rx_q.size() - base), 32'd386);
    chk_eq("rst_after_busy", 32'(busy), 32'd1);
    chk_eq("rst_after_frame_cnt", 32'(frame_cnt), 32'd0);
    base = rx_q.size();
    run_frame(19, 1'b1, -1);
    chk_eq("post_rst_words", 32'(rx_q.size() - base), 32'd576);
    chk_eq("post_rst_tuser0", 32'(rx_q[base].u), 32'd1);
    chk_eq("post_rst_frame_cnt", 32'(frame_cnt), st(1));
    chk_eq("post_rst_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nes_frame_streamer.md
NES_FRAME_STREAMER -- requirements
Module: nes_frame_streamer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning output buffer depth in 32-bit words (power of 2, >=4).
REQ-002 SHALL have ports, in order:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- pix_ce  in  1  PPU pixel strobe; one clk pulse per PPU cycle (1/4 of clk).
- color  in  6  PPU pixel colour index.
- scanline  in  9  current PPU scanline.
- cycle  in  9  current PPU cycle.
- enable  in  1  capture enable (level).
- single  in  1  one-shot mode when 1.
- m_axis_tdata  out  32  packed pixels.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tlast  out  1  last word of a line.
- m_axis_tuser  out  1  first word of a frame.
- busy  out  1  state is not IDLE.
- overflow  out  1  sticky drop flag.
- frame_cnt  out  16  frames completed.
- drop_cnt  out  16  frames aborted.

Function
REQ-003 SHALL sample color/scanline/cycle only on clk edges where pix_ce=1.
REQ-004 SHALL treat a sampled pixel as visible iff scanline<240 and 1<=cycle<=256; x = cycle-1.
REQ-005 SHALL pack pixel x into byte lane x[1:0] of the word: lane n = tdata[8n+7:8n], bits [8n+7:8n+6] = 0.
REQ-006 SHALL push one word into the FIFO on the clk edge after the lane-3 pixel is sampled; 64 words per line, 15360 per frame.
REQ-007 SHALL have states IDLE, ARMED, CAPTURE, RESYNC.
REQ-008 IDLE->ARMED when enable=1.
REQ-009 ARMED->CAPTURE on the visible pixel at scanline 0, cycle 1; that pixel is the frame's first.
REQ-010 ARMED->IDLE immediately when enable=0.
REQ-011 CAPTURE->ARMED after the word for (239,256) is pushed, if enable=1 and single=0; otherwise CAPTURE->IDLE.
REQ-012 enable=0 during CAPTURE SHALL take effect only at frame end.
REQ-013 A push into a full FIFO SHALL drop that word, set overflow, increment drop_cnt, and go CAPTURE->RESYNC.
REQ-014 RESYNC->ARMED (or IDLE if enable=0) when a pixel with scanline>=240 is sampled.
REQ-015 Words already queued SHALL drain normally during RESYNC.
REQ-016 m_axis_tuser=1 only on the word holding pixels (0,0..3).
REQ-017 m_axis_tlast=1 on the word holding x=252..255 of every line.
REQ-018 The FIFO SHALL be first-word-fall-through with registered output: a word pushed into an empty FIFO gives tvalid=1 on the following clk.
REQ-019 tdata/tlast/tuser SHALL hold stable while tvalid=1 and tready=0.
REQ-020 The FIFO SHALL pop on tvalid&tready.
REQ-021 A simultaneous push and pop on a full FIFO SHALL be accepted (no overflow).
REQ-022 frame_cnt SHALL increment on each CAPTURE exit per REQ-011 and wrap modulo 2^16.
REQ-023 overflow SHALL clear only on reset or on an IDLE->ARMED transition.

Reset
REQ-024 rst=0 SHALL asynchronously force: state IDLE; FIFO empty; tvalid/tlast/tuser/tdata = 0; busy = 0; overflow = 0; counters = 0; packing register cleared.
REQ-025 Reset deassertion mid-frame SHALL resume in IDLE; capture starts at the next frame start only.

Configuration
REQ-026 With macro NES_FRAME_STREAMER_STATS_EN defined, frame_cnt and drop_cnt SHALL be live per REQ-013/REQ-022.
REQ-027 Without NES_FRAME_STREAMER_STATS_EN, both ports SHALL be constant 0 and no counter flops are inferred; overflow behaviour is unchanged.

Structure
REQ-028 Package nes_cap_pkg SHALL hold H_VIS=256, V_VIS=240, WORDS_PER_LINE=64, and the state enum typedef.
REQ-029 The FIFO SHALL be sub-module nes_cap_fifo (sync, parameterised width/depth, full/empty).

Verification
REQ-030 enable=1, tready=1, one frame of color=x[5:0] -> 15360 words; first word 0x03020100 with tuser=1; word 63 0x3F3E3D3C with tlast=1; frame_cnt=1.
REQ-031 single=1, two frames -> exactly 15360 words, then busy=0.
REQ-032 tready=0 for entire line 5 -> overflow=1, drop_cnt=1, RESYNC; next frame streams fully with tuser on its first word.
REQ-033 tready toggling 50% -> no overflow; tdata stable while stalled; word order intact.
REQ-034 enable dropped at (100,50) -> frame completes, then IDLE; rst low at (10,10) -> all outputs 0 at once, FIFO empty.
REQ-035 Build without NES_FRAME_STREAMER_STATS_EN, rerun REQ-032 -> overflow=1, drop_cnt=0.
